// File: rtl/bus_data_mem_responder_if.sv
// Load/store data bus between the core (master) and a data-memory responder (slave).
interface bus_data_mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  funct3;
  logic        ready;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, we, addr, wdata, funct3, input ready, rdata, err);
  modport slave  (input req, we, addr, wdata, funct3, output ready, rdata, err);
endinterface

// File: rtl/bus_data_mem_responder.sv
// Multi-cycle data-bus responder: byte/half/word loads and stores on a word-organised RAM
// built from four byte lanes, with a fixed wait and a one-cycle ready/err response.
module bus_data_mem_responder #(
  parameter int          ADDR_WIDTH  = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  bus_data_mem_responder_if.slave   bus
);

  localparam int          DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [32:0] SPAN     = 33'd4 << ADDR_WIDTH;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      cnt_reg, cnt_next;
  logic            accept, resp_fire;

  logic            we_reg;
  logic [31:0]     addr_reg, wdata_reg;
  logic [2:0]      f3_reg;

  logic            ready_reg, err_reg;
  logic [31:0]     rdata_reg, rdata_next;

  logic [31:0]     offset;
  logic            in_range, size_bad, misalign, err_c;
  logic [ADDR_WIDTH-1:0] rd_idx, wr_idx;
  logic [31:0]     word_q;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (bus.req) begin
          if (WAIT_CYCLES == 0) begin
            state_next = ST_RESP;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_reg == 4'd0) state_next = ST_RESP;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    accept    = (state_reg == ST_IDLE) && bus.req;
    resp_fire = (state_reg == ST_RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_reg    <= 1'b0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      f3_reg    <= 3'd0;
    end else if (accept) begin
      we_reg    <= bus.we;
      addr_reg  <= bus.addr;
      wdata_reg <= bus.wdata;
      f3_reg    <= bus.funct3;
    end
  end

  // Addresses below BASE_ADDR wrap to huge offsets and fail the range compare.
  always_comb begin
    offset   = addr_reg - BASE_ADDR;
    in_range = {1'b0, offset} < SPAN;
    size_bad = we_reg ? (f3_reg[2] || (f3_reg[1:0] == 2'b11))
                      : ((f3_reg[1:0] == 2'b11) || (f3_reg == 3'b110));
    misalign = ((f3_reg[1:0] == 2'b01) && addr_reg[0]) ||
               ((f3_reg[1:0] == 2'b10) && (addr_reg[1:0] != 2'b00));
    err_c    = !in_range || size_bad || misalign;
  end

  // The RAM is read at the accept edge straight from the bus address, so the
  // registered read data is available throughout the RESP cycle for any wait count.
  assign rd_idx = ADDR_WIDTH'((bus.addr - BASE_ADDR) >> 2);
  assign wr_idx = ADDR_WIDTH'(offset >> 2);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] ram [DEPTH];
      logic [7:0] q_reg;
      logic [7:0] lane_wd;
      logic       lane_sel;
      logic       lane_we;

      always_comb begin
        lane_wd  = wdata_reg[8*gi +: 8];
        lane_sel = 1'b1;
        case (f3_reg[1:0])
          2'b00: begin
            lane_wd  = wdata_reg[7:0];
            lane_sel = (addr_reg[1:0] == 2'(gi));
          end
          2'b01: begin
            lane_wd  = wdata_reg[8*(gi%2) +: 8];
            lane_sel = (addr_reg[1] == 1'(gi/2));
          end
          default: ;
        endcase
      end

      assign lane_we = resp_fire && we_reg && !err_c && lane_sel;

      // A reset arriving on the commit edge suppresses the write.
      always_ff @(posedge clk) begin
        if (lane_we && !reset) ram[wr_idx] <= lane_wd;
        if (accept)            q_reg       <= ram[rd_idx];
      end

      assign word_q[8*gi +: 8] = q_reg;
    end
  endgenerate

  always_comb begin
    byte_sel   = word_q[{addr_reg[1:0], 3'b000} +: 8];
    half_sel   = addr_reg[1] ? word_q[31:16] : word_q[15:0];
    rdata_next = 32'd0;
    case (f3_reg)
      3'b000:  rdata_next = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  rdata_next = {{16{half_sel[15]}}, half_sel};
      3'b010:  rdata_next = word_q;
      3'b100:  rdata_next = {24'd0, byte_sel};
      3'b101:  rdata_next = {16'd0, half_sel};
      default: rdata_next = 32'd0;
    endcase
    if (err_c || we_reg) rdata_next = 32'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_reg <= 1'b0;
      rdata_reg <= 32'd0;
      err_reg   <= 1'b0;
    end else begin
      ready_reg <= resp_fire;
      if (resp_fire) begin
        rdata_reg <= rdata_next;
        err_reg   <= err_c;
      end
    end
  end

  assign bus.ready = ready_reg;
  assign bus.rdata = rdata_reg;
  assign bus.err   = err_reg;

endmodule

// File: tb/tb_bus_data_mem_responder.sv
// Scoreboard bench: three responders (wait 0/1/3) against a byte-addressed reference model.
module tb_bus_data_mem_responder;

  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam int          NBYTES = 1024;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  logic        req_d   [3];
  logic        we_d    [3];
  logic [31:0] addr_d  [3];
  logic [31:0] wdata_d [3];
  logic [2:0]  f3_d    [3];
  logic        rdy     [3];
  logic        err_o   [3];
  logic [31:0] rd_o    [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      localparam int WC = (gi == 0) ? 0 : ((gi == 1) ? 1 : 3);
      bus_data_mem_responder_if bi ();
      assign bi.req     = req_d[gi];
      assign bi.we      = we_d[gi];
      assign bi.addr    = addr_d[gi];
      assign bi.wdata   = wdata_d[gi];
      assign bi.funct3  = f3_d[gi];
      assign rdy[gi]    = bi.ready;
      assign err_o[gi]  = bi.err;
      assign rd_o[gi]   = bi.rdata;
      bus_data_mem_responder #(
        .ADDR_WIDTH (8),
        .BASE_ADDR  (BASE),
        .WAIT_CYCLES(WC)
      ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bi)
      );
    end
  endgenerate

  typedef struct {
    int          inst;
    logic [31:0] rd;
    logic        err;
    int          acc;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         mon_e;
  int           errors   = 0;
  int           checks   = 0;
  bit           quiet    = 1'b0;
  bit           rst_seen = 1'b0;
  byte unsigned mb[3][NBYTES];

  function automatic int wc(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every ready pulse against the head of the scoreboard.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst_seen && reset) begin
        checks++;
        if (rdy[k] !== 1'b0 || rd_o[k] !== 32'd0 || err_o[k] !== 1'b0) begin
          errors++;
          $display("FAIL reset_state inst=%0d ready=%b rdata=%h err=%b required 0/00000000/0",
                   k, rdy[k], rd_o[k], err_o[k]);
        end
      end
      if (quiet && k == 1) begin
        checks++;
        if (rdy[k] !== 1'b0) begin
          errors++;
          $display("FAIL abort_no_ready inst=%0d ready=%b required 0", k, rdy[k]);
        end
      end else if (rdy[k] === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready inst=%0d rdata=%h err=%b required no response", k, rd_o[k], err_o[k]);
        end else begin
          mon_e = sb_q.pop_front();
          $display("resp inst=%0d rdata=%h err=%b latency=%0d", k, rd_o[k], err_o[k], cyc - mon_e.acc);
          checks += 4;
          if (mon_e.inst != k) begin
            errors++;
            $display("FAIL resp_inst got=%0d required=%0d", k, mon_e.inst);
          end
          if (rd_o[k] !== mon_e.rd) begin
            errors++;
            $display("FAIL rdata inst=%0d got=%h required=%h", k, rd_o[k], mon_e.rd);
          end
          if (err_o[k] !== mon_e.err) begin
            errors++;
            $display("FAIL err inst=%0d got=%b required=%b", k, err_o[k], mon_e.err);
          end
          if (cyc - mon_e.acc != wc(k) + 1) begin
            errors++;
            $display("FAIL latency inst=%0d got=%0d required=%0d", k, cyc - mon_e.acc, wc(k) + 1);
          end
        end
      end
    end
    if (sb_q.size() > 0 && cyc > sb_q[0].acc + wc(sb_q[0].inst) + 8) begin
      checks++;
      errors++;
      $display("FAIL timeout inst=%0d no ready after %0d cycles required %0d",
               sb_q[0].inst, cyc - sb_q[0].acc, wc(sb_q[0].inst) + 1);
      void'(sb_q.pop_front());
    end
    rst_seen = reset;
  end

  // Reference model: byte-addressed memory, access rules applied directly.
  task automatic model(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f, output logic [31:0] rd, output logic e);
    logic [31:0] off;
    logic [31:0] v;
    int          sz;
    bit          sgn;
    bit          bad;
    off = a - BASE;
    bad = 1'b0;
    sgn = 1'b0;
    sz  = 4;
    case (f)
      3'd0: begin sz = 1; sgn = 1'b1; end
      3'd1: begin sz = 2; sgn = 1'b1; end
      3'd2: sz = 4;
      3'd4: sz = 1;
      3'd5: sz = 2;
      default: bad = 1'b1;
    endcase
    if (w && f[2]) bad = 1'b1;
    if (off >= 32'(NBYTES)) bad = 1'b1;
    if ((a & 32'(sz - 1)) != 32'd0) bad = 1'b1;
    e  = bad;
    rd = 32'd0;
    if (!bad) begin
      if (w) begin
        for (int i = 0; i < sz; i++) mb[k][off + 32'(i)] = d[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = mb[k][off + 32'(i)];
        if (sgn && v[8*sz-1])
          for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
        rd = v;
      end
    end
  endtask

  // Issue one request at the current negedge; with hold=1 req stays high across ready.
  task automatic txn(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] f, input bit hold, input bit use_c,
                     input logic [31:0] c_rd, input bit c_err);
    exp_t        e;
    logic [31:0] mrd;
    logic        merr;
    int          n;
    req_d[k]   = 1'b1;
    we_d[k]    = w;
    addr_d[k]  = a;
    wdata_d[k] = d;
    f3_d[k]    = f;
    model(k, w, a, d, f, mrd, merr);
    @(negedge clk);
    e.inst = k;
    e.acc  = cyc;
    e.rd   = use_c ? c_rd  : mrd;
    e.err  = use_c ? c_err : merr;
    sb_q.push_back(e);
    n = 0;
    while (rdy[k] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!hold) req_d[k] = 1'b0;
  endtask

  logic [2:0] lf[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    int          k, pk, sz, n;
    bit          w, hold, hold_prev;
    logic [2:0]  f;
    logic [31:0] a;

    for (int i = 0; i < 3; i++) begin
      req_d[i] = 1'b0; we_d[i] = 1'b0; addr_d[i] = 32'd0; wdata_d[i] = 32'd0; f3_d[i] = 3'd0;
      for (int j = 0; j < NBYTES; j++) mb[i][j] = 8'd0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed scenarios on the WAIT_CYCLES=1 instance.
    txn(1, 1, BASE + 32'h4, 32'hDEADBEEF, 3'd2, 0, 1, 32'h0, 0);
    txn(1, 0, BASE + 32'h4, 32'h0,        3'd2, 0, 1, 32'hDEADBEEF, 0);
    txn(1, 1, BASE + 32'h5, 32'h00000080, 3'd0, 0, 1, 32'h0, 0);
    txn(1, 0, BASE + 32'h5, 32'h0,        3'd0, 0, 1, 32'hFFFFFF80, 0);
    txn(1, 0, BASE + 32'h5, 32'h0,        3'd4, 0, 1, 32'h00000080, 0);
    txn(1, 0, BASE + 32'h4, 32'h0,        3'd2, 0, 1, 32'hDEAD80EF, 0);
    txn(1, 1, BASE + 32'h6, 32'h12348001, 3'd1, 0, 1, 32'h0, 0);
    txn(1, 0, BASE + 32'h6, 32'h0,        3'd1, 0, 1, 32'hFFFF8001, 0);
    txn(1, 0, BASE + 32'h6, 32'h0,        3'd5, 0, 1, 32'h00008001, 0);
    txn(1, 0, BASE + 32'h4, 32'h0,        3'd2, 0, 1, 32'h800180EF, 0);
    txn(1, 1, BASE + 32'h0, 32'h11223344, 3'd2, 0, 1, 32'h0, 0);
    txn(1, 1, BASE + 32'h2, 32'h55667788, 3'd2, 0, 1, 32'h0, 1);
    txn(1, 0, BASE + 32'h0, 32'h0,        3'd2, 0, 1, 32'h11223344, 0);
    txn(1, 1, BASE + 32'h400, 32'h1,      3'd2, 0, 1, 32'h0, 1);
    txn(1, 0, 32'h0FFF_FFFC, 32'h0,       3'd2, 0, 1, 32'h0, 1);
    txn(1, 0, BASE + 32'h0, 32'h0,        3'd3, 0, 1, 32'h0, 1);
    repeat (2) @(negedge clk);

    // Back-to-back: req held high through the first ready.
    txn(1, 1, BASE + 32'hC, 32'hCAFEF00D, 3'd2, 1, 1, 32'h0, 0);
    txn(1, 0, BASE + 32'hC, 32'h0,        3'd2, 0, 1, 32'hCAFEF00D, 0);
    repeat (2) @(negedge clk);

    // Reset in the WAIT cycle of a store aborts it.
    quiet      = 1'b1;
    req_d[1]   = 1'b1;
    we_d[1]    = 1'b1;
    addr_d[1]  = BASE + 32'h8;
    wdata_d[1] = 32'hA5A5A5A5;
    f3_d[1]    = 3'd2;
    @(negedge clk);
    reset    = 1'b1;
    req_d[1] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    quiet = 1'b0;
    txn(1, 0, BASE + 32'h8, 32'h0, 3'd2, 0, 1, 32'h0, 0);
    repeat (2) @(negedge clk);

    // Latency with WAIT_CYCLES=0 and 3.
    for (int i = 0; i < 3; i += 2) begin
      txn(i, 1, BASE + 32'h4, 32'hDEADBEEF, 3'd2, 0, 1, 32'h0, 0);
      txn(i, 0, BASE + 32'h4, 32'h0,        3'd2, 0, 1, 32'hDEADBEEF, 0);
      repeat (2) @(negedge clk);
    end

    // Randomised traffic against the model.
    hold_prev = 1'b0;
    pk        = 0;
    for (int i = 0; i < 150; i++) begin
      k = hold_prev ? pk : int'($urandom_range(0, 2));
      w = 1'($urandom % 2);
      if ($urandom % 5 == 0) f = 3'($urandom % 8);
      else if (w)            f = 3'($urandom % 3);
      else                   f = lf[$urandom % 5];
      sz = (f[1:0] == 2'b00) ? 1 : ((f[1:0] == 2'b01) ? 2 : 4);
      case ($urandom % 10)
        0:       a = BASE + 32'(NBYTES) + ($urandom % 64);
        1:       a = BASE - 32'($urandom_range(1, 16));
        2:       a = BASE + ($urandom % NBYTES);
        default: a = BASE + (($urandom % NBYTES) & ~32'(sz - 1));
      endcase
      hold = (i < 149) && ($urandom % 3 == 0);
      txn(k, w, a, $urandom, f, hold, 0, 32'h0, 0);
      if (!hold) repeat ($urandom % 3) @(negedge clk);
      hold_prev = hold;
      pk        = k;
    end

    n = 0;
    while (sb_q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
